// File: rtl/mapper_pkg.sv
// Shared types and constants for the transmit symbol mapper.
// Holds the word-class encoding, protocol widths and the DOUBLE flip-pair table.
// Used by the mapper and by anything that needs the same pattern classification.
package mapper_pkg;

  localparam int NUM_SYM     = 7;
  localparam int DATA_W      = 16;
  localparam int PAY_W       = 14;
  localparam int SINGLE_BASE = 4;
  localparam int DOUBLE_BASE = 44;
  localparam int NUM_PAIRS   = 20;

  typedef enum logic [1:0] {
    CLS_PLAIN  = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_DOUBLE = 2'd2
  } cls_t;

  typedef logic [NUM_SYM-1:0] sym_vec_t;

  // Flip pairs (p<q) ordered by p then q; (5,6) is not a legal pair.
  function automatic sym_vec_t double_pair(input logic [4:0] idx);
    sym_vec_t pat;
    case (idx)
      5'd0:    pat = 7'h03;
      5'd1:    pat = 7'h05;
      5'd2:    pat = 7'h09;
      5'd3:    pat = 7'h11;
      5'd4:    pat = 7'h21;
      5'd5:    pat = 7'h41;
      5'd6:    pat = 7'h06;
      5'd7:    pat = 7'h0A;
      5'd8:    pat = 7'h12;
      5'd9:    pat = 7'h22;
      5'd10:   pat = 7'h42;
      5'd11:   pat = 7'h0C;
      5'd12:   pat = 7'h14;
      5'd13:   pat = 7'h24;
      5'd14:   pat = 7'h44;
      5'd15:   pat = 7'h18;
      5'd16:   pat = 7'h28;
      5'd17:   pat = 7'h48;
      5'd18:   pat = 7'h30;
      5'd19:   pat = 7'h50;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/mapper_pattern_lut.sv
// Classifies a data word from its top six bits and returns its flip pattern.
// Purely combinational; no state, no handshake.
// Shared between the mapper and the matching demapper checks.
module mapper_pattern_lut
  import mapper_pkg::*;
(
  input  logic [5:0] top_bits,
  output cls_t       cls,
  output sym_vec_t   flip
);

  logic [3:0] nib;
  logic [5:0] dbl_off;

  assign nib     = top_bits[5:2];
  assign dbl_off = top_bits - 6'(DOUBLE_BASE);

  // PLAIN when the top two bits are clear, SINGLE for nibble 4..10, DOUBLE otherwise (44..63).
  always_comb begin
    cls  = CLS_PLAIN;
    flip = '0;
    if (top_bits[5:4] == 2'b00) begin
      cls  = CLS_PLAIN;
      flip = '0;
    end else if (nib <= 4'd10) begin
      cls  = CLS_SINGLE;
      flip = 7'(1) << (nib - 4'(SINGLE_BASE));
    end else begin
      cls  = CLS_DOUBLE;
      flip = double_pair(dbl_off[4:0]);
    end
  end

endmodule

// File: rtl/mapper.sv
// Transmit symbol mapper: 16-bit word -> 7 symbols of {flip, rotation, polarity}.
// Two register stages: word accepted in one cycle is on the outputs two cycles later.
// Ready is the stage-1 advance term; a stalled output holds both stages and drops tx_ready.
module mapper
  import mapper_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [NUM_SYM-1:0]  tx_flip,
  output logic [NUM_SYM-1:0]  tx_rotation,
  output logic [NUM_SYM-1:0]  tx_polarity,
  output logic                out_valid,
  input  logic                out_ready
);

  cls_t             lut_cls;
  sym_vec_t         lut_flip;

  logic             s1_valid;
  logic [PAY_W-1:0] s1_payload;
  cls_t             s1_cls;
  sym_vec_t         s1_flip;

  logic             adv1;
  logic             adv2;

  logic [PAY_W-1:0] payload;
  logic [2:0]       cursor;
  logic [1:0]       pair;
  sym_vec_t         nxt_rot;
  sym_vec_t         nxt_pol;

  mapper_pattern_lut u_lut (
    .top_bits (tx_data[15:10]),
    .cls      (lut_cls),
    .flip     (lut_flip)
  );

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign tx_ready = adv1;

  // Stage 1: capture the payload bits with the class and flip pattern of the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_payload <= '0;
      s1_cls     <= CLS_PLAIN;
      s1_flip    <= '0;
    end else if (adv1) begin
      s1_valid <= tx_valid;
      if (tx_valid) begin
        s1_payload <= tx_data[PAY_W-1:0];
        s1_cls     <= lut_cls;
        s1_flip    <= lut_flip;
      end
    end
  end

  // Stage 2 compaction: a cursor walks the payload two bits at a time, skipping flipped symbols.
  always_comb begin
    case (s1_cls)
      CLS_SINGLE: payload = {2'b00, s1_payload[11:0]};
      CLS_DOUBLE: payload = {4'b0000, s1_payload[9:0]};
      default:    payload = s1_payload;
    endcase
    cursor  = 3'd0;
    pair    = 2'b00;
    nxt_rot = '0;
    nxt_pol = '0;
    for (int j = 0; j < NUM_SYM; j++) begin
      pair = 2'(payload >> (2 * cursor));
      if (!s1_flip[j]) begin
        nxt_pol[j] = pair[0];
        nxt_rot[j] = pair[1];
        cursor     = cursor + 3'd1;
      end
    end
  end

  // Stage 2 register: loads on advance, holds the symbol vectors while the line driver stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      tx_flip     <= '0;
      tx_rotation <= '0;
      tx_polarity <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        tx_flip     <= s1_flip;
        tx_rotation <= nxt_rot;
        tx_polarity <= nxt_pol;
      end
    end
  end

endmodule

// File: tb/tb_mapper.sv
// Bench for the symbol mapper: directed vector table, hand-written pipeline sequences,
// and a loopback through an independent demapper model with random backpressure.
module tb_mapper;

  logic        clk;
  logic        rst_n;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [6:0]  tx_flip;
  logic [6:0]  tx_rotation;
  logic [6:0]  tx_polarity;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] data;
    logic [6:0]  flip;
    logic [6:0]  pol;
    logic [6:0]  rot;
  } vec_t;

  vec_t tbl[$];

  mapper dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_flip     (tx_flip),
    .tx_rotation (tx_rotation),
    .tx_polarity (tx_polarity),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] d, input logic [6:0] f,
                              input logic [6:0] p, input logic [6:0] r);
    vec_t v;
    v.data = d;
    v.flip = f;
    v.pol  = p;
    v.rot  = r;
    return v;
  endfunction

  task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic check_out(input string nm, input vec_t v);
    n_vec++;
    if (!(out_valid === 1'b1 && tx_flip === v.flip && tx_polarity === v.pol &&
          tx_rotation === v.rot)) begin
      n_err++;
      $display("FAIL %s data=%h: got valid=%b flip=%h pol=%h rot=%h, want valid=1 flip=%h pol=%h rot=%h",
               nm, v.data, out_valid, tx_flip, tx_polarity, tx_rotation, v.flip, v.pol, v.rot);
    end
  endtask

  // Independent inverse: classify by flip weight, rebuild the word from unflipped symbols.
  function automatic logic [15:0] demap(input logic [6:0] f, input logic [6:0] r,
                                        input logic [6:0] pl, output logic legal);
    logic [13:0] pay;
    logic [15:0] d;
    int n, w, k, idx, cnt;
    pay = '0;
    n = 0; w = 0; k = 0; idx = -1; cnt = 0;
    for (int j = 0; j < 7; j++) begin
      if (!f[j]) begin
        pay = pay | ({12'b0, r[j], pl[j]} << (2 * n));
        n++;
      end else begin
        w++;
        k = j;
      end
    end
    for (int a = 0; a < 6; a++) begin
      for (int b = a + 1; b < 7; b++) begin
        if (!(a == 5 && b == 6)) begin
          if (f == ((7'(1) << a) | (7'(1) << b))) idx = cnt;
          cnt++;
        end
      end
    end
    case (w)
      0:       d = {2'b00, pay};
      1:       d = {4'(k + 4), pay[11:0]};
      2:       d = {6'(44 + idx), pay[9:0]};
      default: d = 16'hxxxx;
    endcase
    legal = (w <= 2) && (f != 7'h60) && (((r | pl) & f) == 7'h00) && !(w == 2 && idx < 0);
    return d;
  endfunction

  function automatic logic [15:0] lb_word(input int i);
    return 16'(i * 32 + ((i * 7) % 32));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vc;
    vec_t seq[4];
    int idx, cyc;
    logic [15:0] exp_q[$];
    logic [15:0] w, dec;
    logic legal;
    localparam int LB_N = 2048;

    tbl.push_back(mk(16'h3ABC, 7'h00, 7'h46, 7'h7E));
    tbl.push_back(mk(16'h0000, 7'h00, 7'h00, 7'h00));
    tbl.push_back(mk(16'h3FFF, 7'h00, 7'h7F, 7'h7F));
    tbl.push_back(mk(16'h2AAA, 7'h00, 7'h00, 7'h7F));
    tbl.push_back(mk(16'h4FFF, 7'h01, 7'h7E, 7'h7E));
    tbl.push_back(mk(16'h5002, 7'h02, 7'h00, 7'h01));
    tbl.push_back(mk(16'h5555, 7'h02, 7'h7D, 7'h00));
    tbl.push_back(mk(16'h7001, 7'h08, 7'h01, 7'h00));
    tbl.push_back(mk(16'hA000, 7'h40, 7'h00, 7'h00));
    tbl.push_back(mk(16'hAFFF, 7'h40, 7'h3F, 7'h3F));
    tbl.push_back(mk(16'hB3FF, 7'h03, 7'h7C, 7'h7C));
    tbl.push_back(mk(16'hB801, 7'h09, 7'h02, 7'h00));
    tbl.push_back(mk(16'hBFFF, 7'h11, 7'h6E, 7'h6E));
    tbl.push_back(mk(16'hC000, 7'h21, 7'h00, 7'h00));
    tbl.push_back(mk(16'hC401, 7'h41, 7'h02, 7'h00));
    tbl.push_back(mk(16'hC800, 7'h06, 7'h00, 7'h00));
    tbl.push_back(mk(16'hEC00, 7'h18, 7'h00, 7'h00));
    tbl.push_back(mk(16'hF000, 7'h28, 7'h00, 7'h00));
    tbl.push_back(mk(16'hF7FF, 7'h48, 7'h37, 7'h37));
    tbl.push_back(mk(16'hFFFF, 7'h50, 7'h2F, 7'h2F));

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_flip", 32'(tx_flip), 0);
    check_val("rst_rot", 32'(tx_rotation), 0);
    check_val("rst_pol", 32'(tx_polarity), 0);
    check_val("rst_tx_ready", 32'(tx_ready), 1);

    // Table: one word at a time, exact two-cycle latency.
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      tx_valid = 1'b1; tx_data = tbl[i].data;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      @(negedge clk);
      check_val("tbl_latency_early", 32'(out_valid), 0);
      @(posedge clk);
      @(negedge clk);
      check_out("tbl", tbl[i]);
    end

    // Back-to-back stream, outputs on consecutive cycles.
    seq[0] = tbl[4]; seq[1] = tbl[8]; seq[2] = tbl[10]; seq[3] = tbl[19];
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      tx_valid = (c < 4);
      tx_data  = (c < 4) ? seq[c].data : 16'h0000;
      @(negedge clk);
      if (c >= 2) check_out("b2b", seq[c-2]);
    end
    @(posedge clk); @(negedge clk);
    check_val("b2b_drained", 32'(out_valid), 0);

    // Backpressure: both stages fill, ready drops, head word held.
    va = tbl[4]; vb = tbl[8]; vc = tbl[0];
    @(posedge clk); #1;
    out_ready = 1'b0; tx_valid = 1'b1; tx_data = va.data;
    @(negedge clk);
    check_val("bp_ready_empty", 32'(tx_ready), 1);
    @(posedge clk); #1;
    tx_data = vb.data;
    @(negedge clk);
    check_val("bp_ready_one", 32'(tx_ready), 1);
    @(posedge clk); #1;
    tx_data = vc.data;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_val("bp_ready_full", 32'(tx_ready), 0);
      check_out("bp_hold", va);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_ready_release", 32'(tx_ready), 1);
    check_out("bp_first", va);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    @(negedge clk);
    check_out("bp_second", vb);
    @(posedge clk); @(negedge clk);
    check_out("bp_third", vc);
    @(posedge clk); @(negedge clk);
    check_val("bp_drained", 32'(out_valid), 0);

    // Reset with two words in flight.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tx_valid = (c < 2);
      tx_data  = (c == 0) ? tbl[2].data : tbl[19].data;
    end
    check_val("mid_rst_before", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(out_valid), 0);
    check_val("mid_rst_flip", 32'(tx_flip), 0);
    check_val("mid_rst_rot", 32'(tx_rotation), 0);
    check_val("mid_rst_pol", 32'(tx_polarity), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val("post_rst_no_stale", 32'(out_valid), 0);
    end

    // Loopback through the demapper model with random handshakes.
    idx = 0; cyc = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = lb_word(0); out_ready = 1'b1;
    while ((idx < LB_N || exp_q.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("lb_unexpected_output", 32'(out_valid), 0);
        end else begin
          w   = exp_q.pop_front();
          dec = demap(tx_flip, tx_rotation, tx_polarity, legal);
          n_vec++;
          if (dec !== w || !legal) begin
            n_err++;
            $display("FAIL loopback: got word %h legal=%b (flip=%h rot=%h pol=%h), want word %h legal=1",
                     dec, legal, tx_flip, tx_rotation, tx_polarity, w);
          end
        end
      end
      if (tx_valid && tx_ready) begin
        exp_q.push_back(tx_data);
        idx++;
      end
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      tx_valid  = (idx < LB_N) && ($urandom_range(0, 7) != 0);
      tx_data   = lb_word(idx);
      cyc++;
    end
    check_val("lb_all_sent", 32'(idx), 32'(LB_N));
    check_val("lb_all_received", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
